muldiv_unit: RTL
================

Name: muldiv_unit

Overview:
- Multi-cycle MIPS multiply/divide unit with architectural HI/LO registers.
- Sits directly downstream of the register file. Consumes readData1 (rs) and readData2 (rt) for MULT, MULTU, DIV and DIVU.
- Supplies HI/LO to the writeback mux for MFHI/MFLO. Accepts MTHI/MTLO writes.
- Control stalls issue while busy is high.

Parameters:
- WIDTH, 32, operand and HI/LO width. Only 32 is supported and verified.
- DIV0_LO, 32'hFFFFFFFF, LO result on divide-by-zero.

Ports:
- CLK  input  1  system clock; all state updates on posedge.
- Reset_L  input  1  asynchronous active-low reset.
- start  input  1  launch operation; sampled only in IDLE.
- op  input  2  operation select: 00=MULTU, 01=MULT, 10=DIVU, 11=DIV.
- rs_data  input  32  operand A (multiplicand/dividend), from readData1.
- rt_data  input  32  operand B (multiplier/divisor), from readData2.
- mthi  input  1  write rs_data into HI.
- mtlo  input  1  write rs_data into LO.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse when HI/LO updated by an operation.
- hi_out  output  32  current HI.
- lo_out  output  32  current LO.

Behaviour:
- Reset (Reset_L low, async): state=IDLE; HI=0, LO=0; busy=0, done=0; counter=0; internal accumulators cleared.
  - Reset mid-operation aborts the operation with no HI/LO update.
  - Operation resumes only on a new start after Reset_L rises.
- States:
  - IDLE: if start at posedge N, latch op and operands, go to CALC, busy=1.
  - CALC: 32 iterations, one per edge (N+1..N+32), 6-bit counter 0..31.
  - FIX: edge N+33 applies sign correction, writes HI/LO, pulses done, returns to IDLE.
- Latency:
  - busy is high for exactly 33 cycles (after edge N through edge N+33).
  - done is high for the single cycle following edge N+33, with busy=0 in that cycle.
  - A new start is accepted in that cycle.
- Signed ops operate internally on magnitudes. At FIX:
  - Product is negated if the operand signs differ.
  - Quotient is negated if the operand signs differ.
  - Remainder takes the dividend's sign.
- Multiply:
  - Unsigned shift-add over 64 bits.
  - HI = product[63:32], LO = product[31:0].
- Divide:
  - Restoring radix-2.
  - LO = quotient, HI = remainder.
- Divide by zero (rt=0, DIVU or DIV): full 33-cycle latency still applies; LO=DIV0_LO, HI=rs_data as latched.
- DIV overflow, 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- start while busy: ignored. Operands and op do not change the running operation.
- mthi/mtlo:
  - Honoured only in IDLE, and only when start is low. Update on the posedge.
  - mthi and mtlo together write both HI and LO.
  - While busy, mthi/mtlo are ignored.
  - With start high in the same IDLE cycle, start wins and the writes are dropped.
- hi_out/lo_out are registered. They hold previous values throughout CALC and change only at FIX, on mthi/mtlo, or on reset.
- No combinational path from inputs to any output.

Test Plan:
- Reset then idle: Reset_L low for 3 cycles at arbitrary point -> hi_out=0, lo_out=0, busy=0, done=0.
- MULTU: rs=0xFFFFFFFF, rt=0xFFFFFFFF -> after 33 busy cycles, done pulse; HI=0xFFFFFFFE, LO=0x00000001.
- MULT: rs=-3, rt=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- DIV sign rules: rs=-7, rt=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - Then DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU rs=100, rt=0 -> LO=0xFFFFFFFF, HI=100, latency 33.
  - Then MTHI rs=5 in IDLE -> HI=5, LO unchanged.
- Busy interference: during MULTU 6*7, pulse start (op=DIV) and mtlo at cycle 10 -> both ignored; HI=0, LO=42.
  - Second run: assert Reset_L low at cycle 20 -> HI=LO=0, no done pulse.

Source files
------------

// File: rtl/muldiv_unit.sv
// Multi-cycle MIPS multiply/divide unit with architectural HI/LO registers.
// Shift-add multiply and restoring divide on magnitudes, sign fix-up in a final cycle.
module muldiv_unit #(
  parameter int                 WIDTH   = 32,
  parameter logic [WIDTH-1:0]   DIV0_LO = 32'hFFFFFFFF
) (
  input  logic             CLK,
  input  logic             Reset_L,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             mthi,
  input  logic             mtlo,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  state_t                 state_q, state_d;
  logic [5:0]             cnt_q, cnt_d;
  logic                   is_div_q, is_div_d;
  logic                   neg_q, neg_d;
  logic                   sa_q, sa_d;
  logic                   div0_q, div0_d;
  logic                   done_q, done_d;
  logic [WIDTH-1:0]       rs_q, rs_d;
  logic [WIDTH-1:0]       opb_q, opb_d;
  logic [2*WIDTH-1:0]     opa_q, opa_d;
  logic [2*WIDTH-1:0]     acc_q, acc_d;
  logic [WIDTH-1:0]       hi_q, hi_d;
  logic [WIDTH-1:0]       lo_q, lo_d;

  logic                   a_neg, b_neg;
  logic [WIDTH-1:0]       a_mag, b_mag;
  logic [WIDTH:0]         rem_sh, diff;
  logic [2*WIDTH-1:0]     prod_fix;
  logic [WIDTH-1:0]       quo_fix, rem_fix;

  // State register
  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_CALC;
      S_CALC:  if (cnt_q == 6'd31) state_d = S_FIX;
      S_FIX:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs come straight from flops
  always_comb begin
    busy   = (state_q != S_IDLE);
    done   = done_q;
    hi_out = hi_q;
    lo_out = lo_q;
  end

  always_comb begin
    a_neg = op[0] & rs_data[WIDTH-1];
    b_neg = op[0] & rt_data[WIDTH-1];
    a_mag = a_neg ? (~rs_data + 1'b1) : rs_data;
    b_mag = b_neg ? (~rt_data + 1'b1) : rt_data;

    // Divide: acc holds {remainder, dividend/quotient}; shift one dividend bit in per step
    rem_sh = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    diff   = rem_sh - {1'b0, opb_q};

    prod_fix = neg_q ? (~acc_q + 1'b1) : acc_q;
    quo_fix  = neg_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
    rem_fix  = sa_q  ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    sa_d     = sa_q;
    div0_d   = div0_q;
    rs_d     = rs_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    acc_d    = acc_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          cnt_d    = '0;
          is_div_d = op[1];
          neg_d    = a_neg ^ b_neg;
          sa_d     = a_neg;
          div0_d   = (rt_data == '0);
          rs_d     = rs_data;
          opb_d    = b_mag;
          if (op[1]) begin
            acc_d = {{WIDTH{1'b0}}, a_mag};
            opa_d = '0;
          end else begin
            acc_d = '0;
            opa_d = {{WIDTH{1'b0}}, a_mag};
          end
        end else begin
          if (mthi) hi_d = rs_data;
          if (mtlo) lo_d = rs_data;
        end
      end
      S_CALC: begin
        cnt_d = (cnt_q == 6'd31) ? 6'd0 : cnt_q + 6'd1;
        if (is_div_q) begin
          acc_d = {(diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0]),
                   acc_q[WIDTH-2:0], ~diff[WIDTH]};
        end else begin
          if (opb_q[0]) acc_d = acc_q + opa_q;
          opa_d = opa_q << 1;
          opb_d = opb_q >> 1;
        end
      end
      S_FIX: begin
        done_d = 1'b1;
        if (is_div_q) begin
          if (div0_q) begin
            hi_d = rs_q;
            lo_d = DIV0_LO;
          end else begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      sa_q     <= 1'b0;
      div0_q   <= 1'b0;
      rs_q     <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      acc_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      sa_q     <= sa_d;
      div0_q   <= div0_d;
      rs_q     <= rs_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      acc_q    <= acc_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

endmodule
